// File: rtl/wb_reg_writer.sv
// MEM/WB pipeline register and register-file write-back driver.
// Also tracks pending writes to $s0-$s7 so decode can detect RAW hazards.
//
// Valid semantics: an entry in WB is presented on the write port whenever
// wb_valid is set. It is consumed at a clock edge where stall is low or
// flush is high. stall holds the entry; flush discards it. There is no
// ready input: the register file always accepts a write.
module wb_reg_writer #(
  parameter int REG_LO = 16,
  parameter int REG_HI = 23,
  parameter int CNT_W  = 2,
  parameter int ERR_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic                     mem_reg_write,
  input  logic                     mem_to_reg,
  input  logic [4:0]               mem_write_reg,
  input  logic [31:0]              mem_alu_result,
  input  logic [31:0]              mem_read_data,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_reg,
  input  logic                     sq_valid,
  input  logic [4:0]               sq_reg,
  output logic                     reg_write,
  output logic [4:0]               write_reg,
  output logic [31:0]              write_data,
  output logic [REG_HI-REG_LO:0]   busy,
  output logic                     sb_overflow,
  output logic [ERR_W-1:0]         drop_cnt
);

  localparam int NREG = REG_HI - REG_LO + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             wb_valid;
  logic             wb_reg_write;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             ovf_d;
  logic             wb_in_range;
  logic             leave;
  logic             retire_ev;
  logic             drop_ev;
  logic             up;
  logic [1:0]       dn;
  logic [CNT_W:0]   total;
  logic [CNT_W:0]   rem;

  function automatic logic in_range(input logic [4:0] r);
    return (int'(r) >= REG_LO) && (int'(r) <= REG_HI);
  endfunction

  // The WB entry leaves at an edge that is not stalled, or at any flush.
  assign wb_in_range = in_range(write_reg);
  assign leave       = !stall || flush;
  assign retire_ev   = wb_valid && wb_reg_write && wb_in_range && leave;
  assign drop_ev     = wb_valid && wb_reg_write && !wb_in_range && leave;
  assign reg_write   = wb_valid && wb_reg_write && wb_in_range;

  // MEM/WB register: flush beats stall; stall holds everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= mem_valid;
      wb_reg_write <= mem_reg_write;
      write_reg    <= mem_write_reg;
      write_data   <= mem_to_reg ? mem_read_data : mem_alu_result;
    end
  end

  // Next pending count per register: net of issue, retire and squash, clamped.
  always_comb begin
    ovf_d = sb_overflow;
    up    = 1'b0;
    dn    = 2'd0;
    total = '0;
    rem   = '0;
    for (int i = 0; i < NREG; i++) begin
      up    = iss_valid && (int'(iss_reg) == REG_LO + i);
      dn    = {1'b0, retire_ev && (int'(write_reg) == REG_LO + i)}
            + {1'b0, sq_valid && (int'(sq_reg) == REG_LO + i)};
      total = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, up};
      rem   = total - (CNT_W+1)'(dn);
      if (up && (cnt_q[i] == CNT_MAX)) begin
        ovf_d = 1'b1;
      end
      if (total < (CNT_W+1)'(dn)) begin
        cnt_d[i] = '0;
      end else if (rem > {1'b0, CNT_MAX}) begin
        cnt_d[i] = CNT_MAX;
      end else begin
        cnt_d[i] = rem[CNT_W-1:0];
      end
    end
  end

  // Pending-write counters, sticky overflow flag and dropped-write counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      sb_overflow <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sb_overflow <= ovf_d;
      if (drop_ev && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Busy flags come straight from the registered counters.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NREG; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

endmodule

// File: tb/tb_wb_reg_writer.sv
// Testbench for wb_reg_writer: write-port transactions are checked by a
// scoreboard, pending-write tracking and error counters by scenario tasks.
module tb_wb_reg_writer;

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_to_reg;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic        stall;
  logic        flush;
  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic        sq_valid;
  logic [4:0]  sq_reg;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [7:0]  busy;
  logic        sb_overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  wb_reg_writer dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg),
    .mem_write_reg(mem_write_reg), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .stall(stall), .flush(flush),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .sq_valid(sq_valid), .sq_reg(sq_reg),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .busy(busy), .sb_overflow(sb_overflow), .drop_cnt(drop_cnt)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: a write is consumed when the entry leaves WB.
  always @(negedge clock) begin
    if (!reset && reg_write && (!stall || flush)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got reg=%0d data=%h, expected nothing", write_reg, write_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({write_reg, write_data} !== e) begin
          errors++;
          $display("FAIL sb_write: got reg=%0d data=%h, expected reg=%0d data=%h",
                   write_reg, write_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_reg_write = 0; mem_to_reg = 0; mem_write_reg = 0;
    mem_alu_result = 0; mem_read_data = 0;
    iss_valid = 0; iss_reg = 0; sq_valid = 0; sq_reg = 0;
  endtask

  task automatic drive_mem(input logic v, input logic rw, input logic [4:0] r,
                           input logic tr, input logic [31:0] alu, input logic [31:0] rd);
    mem_valid = v; mem_reg_write = rw; mem_write_reg = r; mem_to_reg = tr;
    mem_alu_result = alu; mem_read_data = rd;
    if (v && rw && r >= 16 && r <= 23 && !flush && !stall)
      exp_q.push_back({r, tr ? rd : alu});
    tick();
  endtask

  task automatic idle_tick();
    idle_inputs();
    tick();
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1; stall = 0; flush = 0;
    idle_inputs();
    tick(); tick();
    checks++;
    if ({reg_write, write_reg, write_data, busy, sb_overflow, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rw=%b reg=%0d data=%h busy=%h ovf=%b drop=%0d, expected all 0",
               reg_write, write_reg, write_data, busy, sb_overflow, drop_cnt);
    end
    reset = 0;
  endtask

  task automatic test_alu_write();
    drive_mem(1, 1, 5'd17, 0, 32'h1234, 32'h5555_AAAA);
    checks++;
    if (reg_write !== 1'b1 || write_reg !== 5'd17 || write_data !== 32'h0000_1234) begin
      errors++;
      $display("FAIL alu_write: got rw=%b reg=%0d data=%h, expected 1 17 00001234",
               reg_write, write_reg, write_data);
    end
    idle_tick();
    checks++;
    if (reg_write !== 1'b0) begin
      errors++;
      $display("FAIL alu_write_clear: got rw=%b, expected 0", reg_write);
    end
  endtask

  task automatic test_load_write();
    drive_mem(1, 1, 5'd17, 1, 32'd5, 32'hDEAD_BEEF);
    checks++;
    if (reg_write !== 1'b1 || write_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_write: got rw=%b data=%h, expected 1 deadbeef", reg_write, write_data);
    end
    drive_mem(1, 0, 5'd17, 0, 32'd9, 32'd9);
    checks++;
    if (reg_write !== 1'b0) begin
      errors++;
      $display("FAIL no_reg_write: got rw=%b, expected 0", reg_write);
    end
    idle_tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      logic [4:0]  r;
      logic        tr;
      logic [31:0] a, d;
      r  = 5'($urandom_range(16, 23));
      tr = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      drive_mem(1, 1, r, tr, a, d);
      checks++;
      if (reg_write !== 1'b1 || write_reg !== r || write_data !== (tr ? d : a)) begin
        errors++;
        $display("FAIL b2b_%0d: got rw=%b reg=%0d data=%h, expected 1 %0d %h",
                 k, reg_write, write_reg, write_data, r, tr ? d : a);
      end
    end
    idle_tick();
  endtask

  task automatic test_overflow();
    idle_inputs();
    iss_valid = 1; iss_reg = 5'd20;
    tick();
    checks++;
    if (busy !== 8'h10) begin
      errors++;
      $display("FAIL issue_busy: got busy=%h, expected 10", busy);
    end
    tick(); tick();
    checks++;
    if (sb_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: got ovf=%b, expected 0", sb_overflow);
    end
    tick();
    iss_valid = 0;
    checks++;
    if (sb_overflow !== 1'b1 || busy !== 8'h10) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b busy=%h, expected 1 10", sb_overflow, busy);
    end
    drive_mem(1, 1, 5'd20, 0, 32'h20, 0);
    drive_mem(1, 1, 5'd20, 0, 32'h21, 0);
    drive_mem(1, 1, 5'd20, 0, 32'h22, 0);
    checks++;
    if (busy !== 8'h10) begin
      errors++;
      $display("FAIL retire_partial: got busy=%h, expected 10", busy);
    end
    idle_tick();
    checks++;
    if (busy !== 8'h00 || sb_overflow !== 1'b1) begin
      errors++;
      $display("FAIL retire_all: got busy=%h ovf=%b, expected 00 1", busy, sb_overflow);
    end
  endtask

  task automatic test_issue_retire_same();
    idle_inputs();
    iss_valid = 1; iss_reg = 5'd16;
    tick();
    iss_valid = 0;
    drive_mem(1, 1, 5'd16, 0, 32'h16, 0);
    idle_inputs();
    iss_valid = 1; iss_reg = 5'd16;
    tick();
    iss_valid = 0;
    checks++;
    if (busy !== 8'h01) begin
      errors++;
      $display("FAIL issue_retire_same: got busy=%h, expected 01", busy);
    end
    idle_tick();
    checks++;
    if (busy !== 8'h01) begin
      errors++;
      $display("FAIL issue_retire_hold: got busy=%h, expected 01", busy);
    end
    sq_valid = 1; sq_reg = 5'd16;
    tick();
    tick();
    sq_valid = 0;
    checks++;
    if (busy !== 8'h00) begin
      errors++;
      $display("FAIL squash_floor: got busy=%h, expected 00", busy);
    end
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    iss_valid = 1; iss_reg = 5'd18;
    tick(); tick();
    iss_valid = 0;
    drive_mem(1, 1, 5'd18, 0, 32'hABCD_0018, 0);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      drive_mem(1, 1, 5'd19, 0, 32'h1919_1919, 0);
      checks++;
      if (reg_write !== 1'b1 || write_reg !== 5'd18 || write_data !== 32'hABCD_0018 || busy !== 8'h04) begin
        errors++;
        $display("FAIL stall_hold_%0d: got rw=%b reg=%0d data=%h busy=%h, expected 1 18 abcd0018 04",
                 k, reg_write, write_reg, write_data, busy);
      end
    end
    stall = 0;
    idle_tick();
    checks++;
    if (busy !== 8'h04) begin
      errors++;
      $display("FAIL stall_retire_once: got busy=%h, expected 04", busy);
    end
    sq_valid = 1; sq_reg = 5'd18;
    tick();
    sq_valid = 0;
    checks++;
    if (busy !== 8'h00) begin
      errors++;
      $display("FAIL stall_squash: got busy=%h, expected 00", busy);
    end
    drive_mem(1, 1, 5'd18, 0, 32'h0000_1818, 0);
    stall = 1; flush = 1;
    drive_mem(1, 1, 5'd19, 0, 32'h0000_1919, 0);
    stall = 0; flush = 0;
    checks++;
    if (reg_write !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL flush_stall: got rw=%b drop=%0d, expected 0 0", reg_write, drop_cnt);
    end
    idle_tick();
  endtask

  task automatic test_out_of_range();
    drive_mem(1, 1, 5'd8, 0, 32'h8, 0);
    checks++;
    if (reg_write !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL oor_entry: got rw=%b drop=%0d, expected 0 0", reg_write, drop_cnt);
    end
    idle_tick();
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL oor_drop: got drop=%0d, expected 1", drop_cnt);
    end
    drive_mem(1, 1, 5'd24, 0, 32'h24, 0);
    stall = 1;
    idle_tick();
    idle_tick();
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL oor_stall: got drop=%0d, expected 1", drop_cnt);
    end
    stall = 0;
    idle_tick();
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL oor_release: got drop=%0d, expected 2", drop_cnt);
    end
    idle_inputs();
    iss_valid = 1; iss_reg = 5'd21;
    tick();
    iss_valid = 0;
    drive_mem(1, 1, 5'd21, 0, 32'h0000_CAFE, 0);
    reset = 1;
    #1;
    checks++;
    if ({reg_write, write_reg, write_data, busy, sb_overflow, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rw=%b reg=%0d data=%h busy=%h ovf=%b drop=%0d, expected all 0",
               reg_write, write_reg, write_data, busy, sb_overflow, drop_cnt);
    end
    exp_q.delete();
    idle_inputs();
    tick();
    reset = 0;
  endtask

  task automatic test_drop_saturate();
    for (int k = 1; k <= 256; k++) begin
      logic [4:0] r;
      r = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 15));
      drive_mem(1, 1, r, 0, 32'(k), 0);
      if (k == 100) begin
        checks++;
        if (drop_cnt !== 8'd99) begin
          errors++;
          $display("FAIL drop_count_mid: got drop=%0d, expected 99", drop_cnt);
        end
      end
    end
    idle_tick();
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got drop=%0d, expected 255", drop_cnt);
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_alu_write();
    test_load_write();
    test_back_to_back();
    test_overflow();
    test_issue_retire_same();
    test_stall_flush();
    test_out_of_range();
    test_drop_saturate();
    idle_tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
